// File: rtl/uart_pkg.sv
// Shared definitions for the UART transmit FIFO: default depth and the
// sender FSM state encoding.
package uart_pkg;

   localparam int UART_FIFO_DEPTH  = 16;
   localparam int UART_FIFO_ADDR_W = 4;
   localparam int UART_BYTE_W      = 8;

   typedef logic [1:0] tx_state_t;

   localparam tx_state_t ST_IDLE  = 2'd0;
   localparam tx_state_t ST_SEND  = 2'd1;
   localparam tx_state_t ST_GUARD = 2'd2;
   localparam tx_state_t ST_WAIT  = 2'd3;

endpackage

// File: rtl/fifo_ram.sv
// Simple dual-port storage: one synchronous write port and one read port
// with a registered address, so the array maps onto block RAM.
module fifo_ram #(
   parameter int P_DEPTH  = 16,
   parameter int P_ADDR_W = 4,
   parameter int P_DATA_W = 8
) (
   input  logic                clk,
   input  logic                wr_en,
   input  logic [P_ADDR_W-1:0] wr_addr,
   input  logic [P_DATA_W-1:0] wr_data,
   input  logic [P_ADDR_W-1:0] rd_addr,
   output logic [P_DATA_W-1:0] rd_data
);

   logic [P_DATA_W-1:0] mem_q [P_DEPTH];
   logic [P_ADDR_W-1:0] rd_addr_q;

   always_ff @(posedge clk) begin
      if (wr_en) begin
         mem_q[wr_addr] <= wr_data;
      end
      rd_addr_q <= rd_addr;
   end

   assign rd_data = mem_q[rd_addr_q];

endmodule

// File: rtl/uart_tx_fifo.sv
// Byte FIFO feeding a UART transmitter: queues writes in a circular buffer
// and hands bytes one at a time to the transmitter with a send/guard/wait FSM.
module uart_tx_fifo
   import uart_pkg::*;
#(
   parameter int P_DEPTH  = UART_FIFO_DEPTH,
   parameter int P_ADDR_W = UART_FIFO_ADDR_W
) (
   input  logic                CLK,
   input  logic                RESET,
   input  logic [7:0]          WR_DATA,
   input  logic                WR_EN,
   input  logic                FLUSH,
   output logic                FULL,
   output logic                EMPTY,
   output logic [P_ADDR_W:0]   COUNT,
   output logic                OVERFLOW,
   output logic [7:0]          TX_DATA,
   output logic                TX_DATA_EN,
   input  logic                TX_BUSY
);

   localparam logic [P_ADDR_W:0] DEPTH_CNT = (P_ADDR_W+1)'(P_DEPTH);

   logic [P_ADDR_W-1:0] wr_ptr_q, wr_ptr_d;
   logic [P_ADDR_W-1:0] rd_ptr_q, rd_ptr_d;
   logic [P_ADDR_W:0]   count_q, count_d;
   logic                ovf_q, ovf_d;
   logic [7:0]          tx_data_q, tx_data_d;
   tx_state_t           state_q, state_d;

   logic                full, empty;
   logic                wr_acc, pop;
   logic [P_ADDR_W-1:0] ram_rd_addr;
   logic [7:0]          ram_rd_data;

   // The RAM address register tracks rd_ptr_d, so ram_rd_data is always the head byte.
   assign ram_rd_addr = RESET ? '0 : rd_ptr_d;

   fifo_ram #(
      .P_DEPTH  (P_DEPTH),
      .P_ADDR_W (P_ADDR_W),
      .P_DATA_W (8)
   ) u_ram (
      .clk     (CLK),
      .wr_en   (wr_acc),
      .wr_addr (wr_ptr_q),
      .wr_data (WR_DATA),
      .rd_addr (ram_rd_addr),
      .rd_data (ram_rd_data)
   );

   always_comb begin
      full   = (count_q == DEPTH_CNT);
      empty  = (count_q == '0);
      // FULL is judged on the registered count, so a pop in the same cycle does not free room.
      wr_acc = WR_EN & ~full & ~FLUSH;
      pop    = (state_q == ST_IDLE) & ~empty & ~TX_BUSY & ~FLUSH;
   end

   always_comb begin
      wr_ptr_d  = wr_ptr_q;
      rd_ptr_d  = rd_ptr_q;
      count_d   = count_q;
      ovf_d     = ovf_q;
      tx_data_d = tx_data_q;
      state_d   = state_q;

      if (FLUSH) begin
         wr_ptr_d = '0;
         rd_ptr_d = '0;
         count_d  = '0;
         ovf_d    = 1'b0;
      end else begin
         if (wr_acc) begin
            wr_ptr_d = wr_ptr_q + P_ADDR_W'(1);
         end
         if (pop) begin
            rd_ptr_d = rd_ptr_q + P_ADDR_W'(1);
         end
         unique case ({wr_acc, pop})
            2'b10:   count_d = count_q + (P_ADDR_W+1)'(1);
            2'b01:   count_d = count_q - (P_ADDR_W+1)'(1);
            default: count_d = count_q;
         endcase
         if (WR_EN && full) begin
            ovf_d = 1'b1;
         end
      end

      if (pop) begin
         tx_data_d = ram_rd_data;
      end

      // A flush never aborts the byte already handed to the transmitter.
      unique case (state_q)
         ST_IDLE:  if (pop) state_d = ST_SEND;
         ST_SEND:  state_d = ST_GUARD;
         ST_GUARD: state_d = ST_WAIT;
         ST_WAIT:  if (!TX_BUSY) state_d = ST_IDLE;
         default:  state_d = ST_IDLE;
      endcase
   end

   always_ff @(posedge CLK) begin
      if (RESET) begin
         wr_ptr_q  <= '0;
         rd_ptr_q  <= '0;
         count_q   <= '0;
         ovf_q     <= 1'b0;
         tx_data_q <= 8'h00;
         state_q   <= ST_IDLE;
      end else begin
         wr_ptr_q  <= wr_ptr_d;
         rd_ptr_q  <= rd_ptr_d;
         count_q   <= count_d;
         ovf_q     <= ovf_d;
         tx_data_q <= tx_data_d;
         state_q   <= state_d;
      end
   end

   assign FULL       = full;
   assign EMPTY      = empty;
   assign COUNT      = count_q;
   assign OVERFLOW   = ovf_q;
   assign TX_DATA    = tx_data_q;
   assign TX_DATA_EN = (state_q == ST_SEND);

endmodule

// File: tb/tb_uart_tx_fifo.sv
// Directed bench for uart_tx_fifo: a transmitter busy model, a scoreboard
// queue of expected bytes and a monitor that checks every send pulse.
module tb_uart_tx_fifo;

   logic       clk = 1'b0;
   logic       rst = 1'b1;
   logic [7:0] wr_data = 8'h00;
   logic       wr_en = 1'b0;
   logic       flush = 1'b0;
   logic       full, empty, overflow, tx_en, tx_busy;
   logic [4:0] count;
   logic [7:0] tx_data;

   logic       hold_busy = 1'b0;
   int         busy_len = 20;
   int         busy_cnt = 0;

   int         n_checks = 0;
   int         n_fail = 0;
   int         pulses = 0;
   logic [7:0] exp_q[$];

   uart_tx_fifo #(.P_DEPTH(16), .P_ADDR_W(4)) dut (
      .CLK        (clk),
      .RESET      (rst),
      .WR_DATA    (wr_data),
      .WR_EN      (wr_en),
      .FLUSH      (flush),
      .FULL       (full),
      .EMPTY      (empty),
      .COUNT      (count),
      .OVERFLOW   (overflow),
      .TX_DATA    (tx_data),
      .TX_DATA_EN (tx_en),
      .TX_BUSY    (tx_busy)
   );

   always #5 clk = ~clk;

   // Transmitter model: busy from the send cycle until busy_len cycles later.
   assign tx_busy = hold_busy | tx_en | (busy_cnt != 0);

   always @(posedge clk) begin
      if (rst)              busy_cnt <= 0;
      else if (tx_en)       busy_cnt <= busy_len;
      else if (busy_cnt != 0) busy_cnt <= busy_cnt - 1;
   end

   task automatic check(input string name, input int actual, input int required);
      n_checks++;
      if (actual !== required) begin
         n_fail++;
         $display("FAIL %s: got %0h, required %0h", name, actual, required);
      end
   endtask

   always @(negedge clk) begin
      if (!rst && tx_en) begin
         pulses++;
         if (exp_q.size() == 0) begin
            n_checks++;
            n_fail++;
            $display("FAIL tx_unexpected: got %0h, required no send", tx_data);
         end else begin
            check("tx_byte", int'(tx_data), int'(exp_q.pop_front()));
         end
      end
   end

   task automatic cyc();
      @(posedge clk);
      #1;
   endtask

   task automatic wr(input logic [7:0] b, input bit expect_tx);
      wr_data = b;
      wr_en   = 1'b1;
      if (expect_tx) exp_q.push_back(b);
      cyc();
      wr_en   = 1'b0;
   endtask

   task automatic drain(input int limit);
      int i;
      for (i = 0; i < limit; i++) begin
         cyc();
         if (exp_q.size() == 0 && !tx_busy && empty) break;
      end
      check("drain_done", int'(i < limit), 1);
      repeat (2) cyc();
   endtask

   initial begin
      #500000;
      $display("FAIL watchdog: got timeout, required completion");
      $fatal(1, "watchdog expired");
   end

   initial begin
      int base;
      int i;

      // Reset values
      repeat (3) cyc();
      rst = 1'b0;
      check("rst_count", count, 0);
      check("rst_empty", empty, 1);
      check("rst_full", full, 0);
      check("rst_ovf", overflow, 0);
      check("rst_txdata", tx_data, 8'h00);
      check("rst_txen", tx_en, 0);

      // Three bytes at full UART bit timing
      busy_len  = 1041;
      hold_busy = 1'b1;
      base = pulses;
      wr(8'h41, 1); wr(8'h42, 1); wr(8'h43, 1);
      check("abc_count3", count, 3);
      hold_busy = 1'b0;
      drain(5000);
      check("abc_count0", count, 0);
      check("abc_pulses", pulses - base, 3);

      // First-byte latency and write in the pop cycle
      busy_len = 20;
      base = pulses;
      wr_data = 8'h11; wr_en = 1'b1; exp_q.push_back(8'h11);
      cyc();
      check("lat_count1", count, 1);
      check("lat_noen", tx_en, 0);
      wr_data = 8'h22; exp_q.push_back(8'h22);
      cyc();
      wr_en = 1'b0;
      check("pop_wr_count", count, 1);
      check("lat_en", tx_en, 1);
      check("lat_data", tx_data, 8'h11);
      drain(200);
      check("pop_wr_pulses", pulses - base, 2);

      // Fill to full with transmitter stalled, then overflow
      hold_busy = 1'b1;
      for (i = 0; i < 16; i++) wr(8'h80 + 8'(i), 1);
      check("full_count", count, 16);
      check("full_flag", full, 1);
      check("full_noovf", overflow, 0);
      wr(8'h90, 0);
      check("ovf_count", count, 16);
      check("ovf_flag", overflow, 1);
      hold_busy = 1'b0;
      wr(8'h99, 0);
      check("fullpop_count", count, 15);
      drain(1000);
      check("ovf_sticky", overflow, 1);
      flush = 1'b1;
      cyc();
      flush = 1'b0;
      check("flush_ovf", overflow, 0);
      check("flush_count0", count, 0);

      // Twenty bytes across the pointer wrap
      busy_len  = 3;
      base = pulses;
      hold_busy = 1'b1;
      for (i = 0; i < 12; i++) wr(8'hA0 + 8'(i), 1);
      hold_busy = 1'b0;
      repeat (30) cyc();
      for (i = 12; i < 20; i++) wr(8'hA0 + 8'(i), 1);
      drain(1000);
      check("wrap_pulses", pulses - base, 20);
      check("wrap_noovf", overflow, 0);

      // Flush while waiting on the transmitter
      busy_len  = 50;
      hold_busy = 1'b1;
      wr(8'hC0, 1);
      for (i = 1; i < 6; i++) wr(8'hC0 + 8'(i), 0);
      base = pulses;
      hold_busy = 1'b0;
      for (i = 0; i < 20; i++) begin
         cyc();
         if (tx_en) break;
      end
      check("fl_send_seen", int'(i < 20), 1);
      repeat (3) cyc();
      check("fl_count5", count, 5);
      flush = 1'b1; wr_en = 1'b1; wr_data = 8'hEE;
      cyc();
      flush = 1'b0; wr_en = 1'b0;
      check("fl_count0", count, 0);
      check("fl_empty", empty, 1);
      repeat (150) cyc();
      check("fl_pulses", pulses - base, 1);
      check("fl_txdata_hold", tx_data, 8'hC0);

      // Reset in GUARD, then normal operation
      busy_len = 20;
      wr(8'h55, 1);
      cyc();
      check("g_send", tx_en, 1);
      cyc();
      check("g_guard", tx_en, 0);
      rst = 1'b1;
      cyc();
      rst = 1'b0;
      check("g_rst_count", count, 0);
      check("g_rst_empty", empty, 1);
      check("g_rst_txdata", tx_data, 8'h00);
      check("g_rst_txen", tx_en, 0);
      check("g_rst_ovf", overflow, 0);
      base = pulses;
      wr(8'h66, 1);
      drain(200);
      check("g_after_pulses", pulses - base, 1);
      check("g_after_data", tx_data, 8'h66);

      check("sb_empty", exp_q.size(), 0);
      $display("End of test - %0d assertions evaluated, %0d failures", n_checks, n_fail);
      $finish;
   end

endmodule
